// File: rtl/frame_buf_scheduler.sv
// Frame buffer port scheduler: arbitrates capture, PE and VGA access, sequences the hand-tracking frame loop.
// Latency: write port registered (1 cycle after accept); read address combinational, read data 1 cycle later.
// Backpressure: PE reads yield to active VGA, out-of-range PE requests are refused; capture is dropped while frozen.
// Optional: define FB_SCHED_STATS_EN to add stall_cnt / frames_done statistics outputs.
module frame_buf_scheduler #(
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 16,
  parameter int WORDS_320   = 76800,
  parameter int WORDS_160   = 19200,
  parameter int HOLD_FRAMES = 2,
  parameter int TIMEOUT     = 2000000
) (
  input  logic              clk25,
  input  logic              rst,
  input  logic              ht_mode,
  input  logic              mode,
  input  logic              cap_we,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              cap_eof,
  input  logic [ADDR_W-1:0] vga_addr,
  input  logic              vga_active,
  input  logic              vga_eof,
  output logic [DATA_W-1:0] vga_data,
  output logic              pe_start,
  output logic              pe_abort,
  input  logic              pe_rd_req,
  input  logic [ADDR_W-1:0] pe_rd_addr,
  output logic              pe_rd_gnt,
  output logic              pe_rd_valid,
  output logic [DATA_W-1:0] pe_rd_data,
  input  logic              pe_wr_req,
  input  logic [ADDR_W-1:0] pe_wr_addr,
  input  logic [DATA_W-1:0] pe_wr_data,
  output logic              pe_wr_gnt,
  input  logic              pe_done,
  output logic              buf_wren,
  output logic [ADDR_W-1:0] buf_wraddr,
  output logic [DATA_W-1:0] buf_wrdata,
  output logic [ADDR_W-1:0] buf_rdaddr,
  input  logic [DATA_W-1:0] buf_rddata,
  output logic [2:0]        state_o,
  output logic              err_timeout,
  output logic              err_oob
`ifdef FB_SCHED_STATS_EN
  ,
  output logic [23:0]       stall_cnt,
  output logic [15:0]       frames_done
`endif
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  typedef enum logic [2:0] {
    NORMAL  = 3'd0,
    SYNC    = 3'd1,
    CAPTURE = 3'd2,
    PROCESS = 3'd3,
    DISPLAY = 3'd4
  } state_t;

  state_t            state;
  logic              mode_l;
  logic [TW-1:0]     tcnt;
  logic [HW-1:0]     hold_cnt;

  logic              in_proc;
  logic [ADDR_W-1:0] limit;
  logic              wr_in_rng;
  logic              rd_in_rng;
  logic              wr_acc;
  logic [ADDR_W-1:0] wr_addr_sel;
  logic [DATA_W-1:0] wr_data_sel;

  assign state_o    = state;
  assign vga_data   = buf_rddata;
  assign pe_rd_data = buf_rddata;

  // Port routing and grants; read address stays combinational so RAM data lands one cycle later
  always_comb begin
    in_proc     = (state == PROCESS);
    limit       = mode_l ? ADDR_W'(WORDS_160) : ADDR_W'(WORDS_320);
    wr_in_rng   = (pe_wr_addr < limit);
    rd_in_rng   = (pe_rd_addr < limit);
    pe_wr_gnt   = ~rst & in_proc & pe_wr_req & wr_in_rng;
    pe_rd_gnt   = ~rst & in_proc & pe_rd_req & ~vga_active & rd_in_rng;
    buf_rdaddr  = pe_rd_gnt ? pe_rd_addr : vga_addr;
    wr_acc      = 1'b0;
    wr_addr_sel = cap_addr;
    wr_data_sel = cap_data;
    case (state)
      NORMAL, SYNC, CAPTURE: begin
        wr_acc = cap_we;
      end
      PROCESS: begin
        wr_acc      = pe_wr_gnt;
        wr_addr_sel = pe_wr_addr;
        wr_data_sel = pe_wr_data;
      end
      default: begin
        wr_acc = 1'b0;
      end
    endcase
  end

  // Registered write port and read-valid pipeline
  always_ff @(posedge clk25) begin
    if (rst) begin
      buf_wren    <= 1'b0;
      buf_wraddr  <= '0;
      buf_wrdata  <= '0;
      pe_rd_valid <= 1'b0;
    end else begin
      buf_wren    <= wr_acc;
      pe_rd_valid <= pe_rd_gnt;
      if (wr_acc) begin
        buf_wraddr <= wr_addr_sel;
        buf_wrdata <= wr_data_sel;
      end
    end
  end

  // Frame-loop sequencer with registered pulses, sticky errors and mode latch
  always_ff @(posedge clk25) begin
    if (rst) begin
      state       <= NORMAL;
      mode_l      <= 1'b0;
      tcnt        <= '0;
      hold_cnt    <= '0;
      pe_start    <= 1'b0;
      pe_abort    <= 1'b0;
      err_timeout <= 1'b0;
      err_oob     <= 1'b0;
    end else begin
      pe_start <= 1'b0;
      pe_abort <= 1'b0;
      if (in_proc && ((pe_wr_req && !wr_in_rng) || (pe_rd_req && !rd_in_rng))) begin
        err_oob <= 1'b1;
      end
      if (!ht_mode) begin
        // Leaving hand tracking: the PE is told only if it was mid-frame
        state    <= NORMAL;
        tcnt     <= '0;
        hold_cnt <= '0;
        if (in_proc) begin
          pe_abort <= 1'b1;
        end
      end else begin
        case (state)
          NORMAL: begin
            state <= SYNC;
          end
          SYNC: begin
            if (cap_eof) begin
              state  <= CAPTURE;
              mode_l <= mode;
            end
          end
          CAPTURE: begin
            if (cap_eof) begin
              state    <= PROCESS;
              pe_start <= 1'b1;
              tcnt     <= '0;
            end
          end
          PROCESS: begin
            if (pe_done) begin
              state    <= DISPLAY;
              hold_cnt <= '0;
              tcnt     <= '0;
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
              state       <= CAPTURE;
              mode_l      <= mode;
              pe_abort    <= 1'b1;
              err_timeout <= 1'b1;
              tcnt        <= '0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          DISPLAY: begin
            if (vga_eof) begin
              if (hold_cnt == HW'(HOLD_FRAMES - 1)) begin
                state    <= CAPTURE;
                mode_l   <= mode;
                hold_cnt <= '0;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
          end
          default: begin
            state <= NORMAL;
          end
        endcase
      end
    end
  end

`ifdef FB_SCHED_STATS_EN
  // Statistics: saturating PE read stalls and wrapping count of processed frames
  always_ff @(posedge clk25) begin
    if (rst || (!ht_mode && state != NORMAL)) begin
      stall_cnt   <= '0;
      frames_done <= '0;
    end else begin
      if (in_proc && pe_rd_req && !pe_rd_gnt && stall_cnt != 24'hFFFFFF) begin
        stall_cnt <= stall_cnt + 24'd1;
      end
      if (in_proc && pe_done) begin
        frames_done <= frames_done + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_frame_buf_scheduler.sv
// Testbench for frame_buf_scheduler: directed vectors, corner sequences and a randomized model comparison.
module tb_frame_buf_scheduler;

  localparam int TMO  = 100;
  localparam int HOLD = 2;

  logic        clk25 = 1'b0;
  logic        rst, ht_mode, mode, cap_we, cap_eof, vga_active, vga_eof;
  logic [16:0] cap_addr, vga_addr, pe_rd_addr, pe_wr_addr, buf_wraddr, buf_rdaddr;
  logic [15:0] cap_data, vga_data, pe_rd_data, pe_wr_data, buf_wrdata, buf_rddata;
  logic        pe_start, pe_abort, pe_rd_req, pe_rd_gnt, pe_rd_valid, pe_wr_req, pe_wr_gnt, pe_done;
  logic        buf_wren, err_timeout, err_oob;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;
  int cyc_no = 0;
  int entry;

  frame_buf_scheduler #(.TIMEOUT(TMO), .HOLD_FRAMES(HOLD)) dut (
    .clk25(clk25), .rst(rst), .ht_mode(ht_mode), .mode(mode),
    .cap_we(cap_we), .cap_addr(cap_addr), .cap_data(cap_data), .cap_eof(cap_eof),
    .vga_addr(vga_addr), .vga_active(vga_active), .vga_eof(vga_eof), .vga_data(vga_data),
    .pe_start(pe_start), .pe_abort(pe_abort),
    .pe_rd_req(pe_rd_req), .pe_rd_addr(pe_rd_addr), .pe_rd_gnt(pe_rd_gnt),
    .pe_rd_valid(pe_rd_valid), .pe_rd_data(pe_rd_data),
    .pe_wr_req(pe_wr_req), .pe_wr_addr(pe_wr_addr), .pe_wr_data(pe_wr_data), .pe_wr_gnt(pe_wr_gnt),
    .pe_done(pe_done),
    .buf_wren(buf_wren), .buf_wraddr(buf_wraddr), .buf_wrdata(buf_wrdata),
    .buf_rdaddr(buf_rdaddr), .buf_rddata(buf_rddata),
    .state_o(state_o), .err_timeout(err_timeout), .err_oob(err_oob)
  );

  always #20 clk25 = ~clk25;

  // Frame buffer stand-in: content is a fixed function of address, one-cycle read latency
  function automatic logic [15:0] ramf(input logic [16:0] a);
    return a[15:0] ^ 16'h5AC3 ^ {15'd0, a[16]};
  endfunction

  always @(posedge clk25) buf_rddata <= ramf(buf_rdaddr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_no);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk25);
      #1;
      cyc_no++;
    end
  endtask

  typedef struct {
    logic        we;
    logic [16:0] addr;
    logic [15:0] data;
    logic [16:0] vaddr;
    logic        e_wren;
    logic [16:0] e_wraddr;
    logic [15:0] e_wrdata;
    logic [16:0] e_rdaddr;
  } vec_t;

  vec_t vecs[4];

  // Reference model state for the randomized phase
  int          m_state, m_pcyc, m_eofs, lim;
  logic        m_mode, m_start, m_abort, m_etmo, m_eoob, m_wren, m_rv;
  logic [16:0] m_wa, m_raddr, e_ra;
  logic [15:0] m_wd;
  logic        inproc, e_rg, e_wg;

  initial begin
    rst = 1'b1; ht_mode = 0; mode = 0; cap_we = 0; cap_addr = '0; cap_data = '0; cap_eof = 0;
    vga_addr = '0; vga_active = 0; vga_eof = 0; pe_rd_req = 0; pe_rd_addr = '0;
    pe_wr_req = 0; pe_wr_addr = '0; pe_wr_data = '0; pe_done = 0;

    vecs[0] = '{1'b1, 17'h00100, 16'hF800, 17'h00005, 1'b1, 17'h00100, 16'hF800, 17'h00005};
    vecs[1] = '{1'b1, 17'h1FFFF, 16'h07E0, 17'h12C00, 1'b1, 17'h1FFFF, 16'h07E0, 17'h12C00};
    vecs[2] = '{1'b0, 17'h00042, 16'h001F, 17'h00000, 1'b0, 17'h00000, 16'h0000, 17'h00000};
    vecs[3] = '{1'b1, 17'h12BFF, 16'hFFFF, 17'h1FFFF, 1'b1, 17'h12BFF, 16'hFFFF, 17'h1FFFF};

    // Reset values
    cyc(2);
    chk("rst_state", state_o, 0);
    chk("rst_wren", buf_wren, 0);
    chk("rst_wraddr", buf_wraddr, 0);
    chk("rst_wrdata", buf_wrdata, 0);
    chk("rst_pulses", {pe_start, pe_abort, pe_rd_valid}, 0);
    chk("rst_errs", {err_timeout, err_oob}, 0);
    chk("rst_gnts", {pe_rd_gnt, pe_wr_gnt}, 0);
    rst = 1'b0;

    // Normal-video routing vectors
    for (int i = 0; i < 4; i++) begin
      cap_we = vecs[i].we; cap_addr = vecs[i].addr; cap_data = vecs[i].data;
      vga_addr = vecs[i].vaddr; pe_rd_req = 1'b1; pe_wr_req = 1'b1;
      #1;
      chk("norm_rdaddr", buf_rdaddr, vecs[i].e_rdaddr);
      chk("norm_gnts", {pe_rd_gnt, pe_wr_gnt}, 0);
      cyc(1);
      chk("norm_wren", buf_wren, vecs[i].e_wren);
      if (vecs[i].e_wren) begin
        chk("norm_wraddr", buf_wraddr, vecs[i].e_wraddr);
        chk("norm_wrdata", buf_wrdata, vecs[i].e_wrdata);
      end
      chk("norm_vga_data", vga_data, ramf(vecs[i].e_rdaddr));
      chk("norm_state", state_o, 0);
    end
    cap_we = 0; pe_rd_req = 0; pe_wr_req = 0;

    // Enter hand tracking: eof coincident with entry is ignored
    ht_mode = 1; cap_eof = 1; mode = 1;
    cyc(1); chk("sync_entry", state_o, 1);
    cap_eof = 0; cyc(1); chk("sync_hold", state_o, 1);
    cap_eof = 1; cyc(1); chk("capture_entry", state_o, 2);
    cap_eof = 0; mode = 0; cap_we = 1; cap_addr = 17'h77; cap_data = 16'h1234;
    cyc(1);
    chk("capture_wren", buf_wren, 1);
    chk("capture_wraddr", buf_wraddr, 17'h77);
    cap_we = 0; cap_eof = 1;
    cyc(1); entry = cyc_no;
    chk("process_entry", state_o, 3);
    chk("pe_start_hi", pe_start, 1);
    cap_eof = 0; cyc(1);
    chk("pe_start_lo", pe_start, 0);

    // PROCESS arbitration with small-frame mode latched
    vga_active = 1; vga_addr = 17'h300; pe_rd_req = 1; pe_rd_addr = 17'h10;
    #1;
    chk("rd_gnt_vga_busy", pe_rd_gnt, 0);
    chk("rdaddr_vga", buf_rdaddr, 17'h300);
    cyc(1); chk("rd_valid_none", pe_rd_valid, 0);
    vga_active = 0; #1;
    chk("rd_gnt_free", pe_rd_gnt, 1);
    chk("rdaddr_pe", buf_rdaddr, 17'h10);
    cyc(1);
    chk("rd_valid", pe_rd_valid, 1);
    chk("rd_data", pe_rd_data, ramf(17'h10));
    pe_rd_addr = 17'd19200; #1;
    chk("rd_gnt_oob", pe_rd_gnt, 0);
    pe_rd_req = 0; cap_we = 1; cap_addr = 17'h5;
    cyc(1);
    chk("frozen_wren", buf_wren, 0);
    chk("rd_valid_drop", pe_rd_valid, 0);
    cap_we = 0; pe_wr_req = 1; pe_wr_addr = 17'd19200; pe_wr_data = 16'hBEEF; #1;
    chk("wr_gnt_oob", pe_wr_gnt, 0);
    cyc(1);
    chk("oob_no_write", buf_wren, 0);
    chk("err_oob", err_oob, 1);
    pe_wr_addr = 17'd19199; #1;
    chk("wr_gnt_edge", pe_wr_gnt, 1);
    cyc(1);
    chk("pe_wren", buf_wren, 1);
    chk("pe_wraddr", buf_wraddr, 17'd19199);
    chk("pe_wrdata", buf_wrdata, 16'hBEEF);
    pe_wr_req = 0;

    // Timeout: PROCESS lasts TMO cycles from entry
    while (state_o == 3'd3 && (cyc_no - entry) < 3 * TMO) cyc(1);
    chk("timeout_cycles", cyc_no - entry, TMO);
    chk("timeout_state", state_o, 2);
    chk("timeout_abort", pe_abort, 1);
    chk("err_timeout", err_timeout, 1);
    cyc(1); chk("abort_pulse_end", pe_abort, 0);

    // pe_done path and display hold (full-frame mode latched now)
    cap_eof = 1; cyc(1); chk("process_again", state_o, 3);
    cap_eof = 0; pe_wr_req = 1; pe_wr_addr = 17'd76799; #1;
    chk("wr_gnt_320_edge", pe_wr_gnt, 1);
    pe_wr_addr = 17'd76800; #1;
    chk("wr_gnt_320_oob", pe_wr_gnt, 0);
    pe_wr_req = 0; pe_done = 1;
    cyc(1);
    chk("display_entry", state_o, 4);
    chk("done_no_abort", pe_abort, 0);
    pe_done = 0; cap_we = 1; pe_rd_req = 1; pe_rd_addr = 17'h20; #1;
    chk("display_rd_gnt", pe_rd_gnt, 0);
    cyc(1); chk("display_no_write", buf_wren, 0);
    cap_we = 0; pe_rd_req = 0; vga_eof = 1;
    cyc(1); vga_eof = 0; chk("display_one_eof", state_o, 4);
    cyc(1); chk("display_wait", state_o, 4);
    vga_eof = 1; cyc(1); vga_eof = 0;
    chk("display_exit", state_o, 2);

    // pe_done coincident with the timeout cycle wins
    cap_eof = 1; cyc(1); entry = cyc_no; cap_eof = 0;
    cyc(TMO - 1);
    chk("pre_timeout_state", state_o, 3);
    pe_done = 1; cyc(1); pe_done = 0;
    chk("done_beats_timeout", state_o, 4);
    chk("done_beats_abort", pe_abort, 0);

    // Reset during DISPLAY
    rst = 1; cyc(1);
    chk("rst_disp_state", state_o, 0);
    chk("rst_disp_errs", {err_timeout, err_oob}, 0);
    chk("rst_disp_abort", pe_abort, 0);
    chk("rst_disp_wr", {buf_wren, buf_wraddr, buf_wrdata}, 0);
    rst = 0;

    // ht_mode drop during PROCESS
    cyc(1); cap_eof = 1; cyc(2); cap_eof = 0;
    chk("re_process", state_o, 3);
    ht_mode = 0; cyc(1);
    chk("drop_state", state_o, 0);
    chk("drop_abort", pe_abort, 1);
    cyc(1); chk("drop_abort_end", pe_abort, 0);

    // Randomized phase against the reference model
    rst = 1; cyc(1); rst = 0;
    m_state = 0; m_pcyc = 0; m_eofs = 0; m_mode = 0; m_start = 0; m_abort = 0;
    m_etmo = 0; m_eoob = 0; m_wren = 0; m_rv = 0; m_wa = '0; m_wd = '0; m_raddr = '0;
    for (int it = 0; it < 3000; it++) begin
      ht_mode    = ($urandom_range(0, 299) != 0);
      mode       = 1'($urandom_range(0, 1));
      cap_we     = 1'($urandom_range(0, 1));
      cap_addr   = 17'($urandom);
      cap_data   = 16'($urandom);
      cap_eof    = ($urandom_range(0, 15) == 0);
      vga_eof    = ($urandom_range(0, 7) == 0);
      vga_active = 1'($urandom_range(0, 1));
      vga_addr   = 17'($urandom);
      pe_done    = ($urandom_range(0, 79) == 0);
      pe_rd_req  = 1'($urandom_range(0, 1));
      pe_wr_req  = 1'($urandom_range(0, 1));
      pe_rd_addr = ($urandom_range(0, 1) == 1) ? 17'($urandom_range(19195, 19205)) : 17'($urandom_range(76795, 76805));
      pe_wr_addr = ($urandom_range(0, 1) == 1) ? 17'($urandom_range(19195, 19205)) : 17'($urandom_range(76795, 76805));
      pe_wr_data = 16'($urandom);
      #1;
      inproc = (m_state == 3);
      lim    = m_mode ? 19200 : 76800;
      e_rg   = inproc && pe_rd_req && !vga_active && (int'(pe_rd_addr) < lim);
      e_wg   = inproc && pe_wr_req && (int'(pe_wr_addr) < lim);
      e_ra   = e_rg ? pe_rd_addr : vga_addr;
      chk("r_state", state_o, m_state);
      chk("r_rd_gnt", pe_rd_gnt, e_rg);
      chk("r_wr_gnt", pe_wr_gnt, e_wg);
      chk("r_rdaddr", buf_rdaddr, e_ra);
      chk("r_pulses", {pe_start, pe_abort}, {m_start, m_abort});
      chk("r_errs", {err_timeout, err_oob}, {m_etmo, m_eoob});
      chk("r_wren", buf_wren, m_wren);
      if (m_wren) chk("r_wr", {buf_wraddr, buf_wrdata}, {m_wa, m_wd});
      chk("r_rvalid", pe_rd_valid, m_rv);
      if (m_rv) chk("r_rdata", pe_rd_data, ramf(m_raddr));

      // Model advance for this clock edge
      m_wren = (m_state <= 2) ? cap_we : e_wg;
      if (m_state <= 2 && cap_we) begin m_wa = cap_addr; m_wd = cap_data; end
      if (e_wg) begin m_wa = pe_wr_addr; m_wd = pe_wr_data; end
      m_rv = e_rg; m_raddr = pe_rd_addr;
      m_start = 0; m_abort = 0;
      if (inproc && ((pe_wr_req && int'(pe_wr_addr) >= lim) || (pe_rd_req && int'(pe_rd_addr) >= lim))) m_eoob = 1;
      if (!ht_mode) begin
        m_abort = inproc; m_state = 0;
      end else begin
        case (m_state)
          0: m_state = 1;
          1: if (cap_eof) begin m_state = 2; m_mode = mode; end
          2: if (cap_eof) begin m_state = 3; m_start = 1; m_pcyc = 0; end
          3: begin
            m_pcyc++;
            if (pe_done) begin m_state = 4; m_eofs = 0; end
            else if (m_pcyc == TMO) begin m_state = 2; m_mode = mode; m_abort = 1; m_etmo = 1; end
          end
          default: if (vga_eof) begin
            m_eofs++;
            if (m_eofs == HOLD) begin m_state = 2; m_mode = mode; end
          end
        endcase
      end
      cyc(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
